sr_latch_ctrl: RTL and testbench
================================

Name: sr_latch_ctrl

Overview:
Controller that sequences set and reset operations onto a bank of NOR-based SR latches shared by several requesters.
- Arbitrates round-robin between requesters.
- Converts each accepted request into one clean S or R pulse of fixed width, followed by a guard gap.
- Guarantees the forbidden S=R=1 input is never driven and that two latch inputs are never driven at once.
- Sits between control logic (requesters) and the latch bank's S/R inputs, with optional readback of the latch Q outputs.

Parameters:
- NLATCH, 4: number of latches in the bank; IW = $clog2(NLATCH), minimum 1.
- NREQ, 2: number of requesters.
- PULSE_CYC, 2: S/R pulse width in clk cycles; must be ≥1.
- GAP_CYC, 1: cycles with all S/R low after each pulse; must be ≥1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request; held high until gnt.
- op  input  NREQ  per-requester operation: 1=set, 0=reset.
- idx  input  NREQ*IW  per-requester target latch index; requester k uses bits [k*IW +: IW].
- gnt  output  NREQ  one-cycle, one-hot acceptance pulse.
- done  output  NREQ  one-cycle, one-hot completion pulse.
- S  output  NLATCH  latch set drives.
- R  output  NLATCH  latch reset drives.
- Q  input  NLATCH  latch Q readback; used only with the optional feature.
- busy  output  1  high whenever the FSM is not IDLE.
- err  output  1  sticky error flag.

Behaviour:
- Reset (async, rst_n low): S, R, gnt, done, busy, err all 0; FSM=IDLE; RR pointer=0; counters=0. Assertion mid-pulse drops S/R immediately, without waiting for clk.
- FSM states: IDLE, PULSE, GAP.
- IDLE with any req high:
  - Pick the first set req bit searching from the pointer upward, wrapping modulo NREQ.
  - Capture that requester's op and idx.
  - Next state = PULSE; pointer = granted+1 mod NREQ.
- IDLE with no req: remain in IDLE, all outputs 0.
- gnt: registered; high for exactly the first PULSE cycle, for the granted requester only.
- PULSE:
  - S[idx]=1 (op=1) or R[idx]=1 (op=0) for exactly PULSE_CYC cycles; all other S/R bits 0.
  - Then go to GAP.
- GAP:
  - All S/R = 0 for exactly GAP_CYC cycles.
  - done[granted] is high for the first GAP cycle only.
  - Then go to IDLE.
- Latency: req sampled at edge T; gnt and the S/R pulse start at T+1; done at T+1+PULSE_CYC. Back-to-back period is 1+PULSE_CYC+GAP_CYC cycles (IDLE costs one cycle).
- Requests arriving during PULSE/GAP wait; they are not lost while held.
- A req still high after its gnt counts as a new request at the next IDLE.
- Out-of-range idx (≥NLATCH, possible when NLATCH is not a power of 2):
  - No S/R bit asserted; timing unchanged.
  - done still pulses; err set.
- Invariants, checked every cycle by the bench:
  - (S & R) == 0.
  - popcount(S|R) ≤ 1.
  - gnt and done each one-hot or zero.
- op/idx changes after gnt have no effect on the operation in flight.
- err clears only on reset.

Optional Feature:
SR_CTRL_QCHECK_EN
- Defined: on the first GAP cycle, Q[idx] is compared with the captured op. A mismatch sets err. Q must settle within PULSE_CYC cycles.
- Undefined: Q is ignored (input present but unused) and err is set only by out-of-range idx.
- Port list is identical in both builds.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, no req → S=R=0, gnt=done=busy=err=0 throughout.
2. Single set (PULSE_CYC=2, GAP_CYC=1): req[0]=1, op[0]=1, idx0=2 sampled at edge T → gnt=01 and S=0100 during cycles T+1..T+2; done=01 at T+3; busy low at T+4.
3. Round-robin contention: req=11 held continuously, op=1 for both, idx0=0, idx1=1 → grants alternate 01,10,01 every 4 cycles; S=0001/0010 pulses never overlap, with ≥1 all-zero cycle between pulses.
4. Opposite ops on the same latch: req0 set idx 3, req1 reset idx 3 simultaneously → S[3] pulse, then ≥1 gap cycle, then R[3] pulse; S&R=0 every cycle.
5. Reset mid-pulse: assert rst_n low during the second PULSE cycle → S/R go 0 asynchronously; after release FSM=IDLE, pointer=0, no done emitted.
6. With SR_CTRL_QCHECK_EN: bench model holds Q[1]=0 during a set of idx 1 → err=1 on the first GAP cycle and stays 1. Without the macro, the same stimulus leaves err=0.

Source files
------------

// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer driving single S/R pulses plus a guard gap onto a NOR SR latch bank.
// Optional Q readback check is enabled by defining SR_CTRL_QCHECK_EN.
module sr_latch_ctrl #(
    parameter int NLATCH    = 4,
    parameter int NREQ      = 2,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1,
    localparam int IW       = (NLATCH > 1) ? $clog2(NLATCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IW-1:0]   idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NLATCH-1:0]    S,
    output logic [NLATCH-1:0]    R,
    input  logic [NLATCH-1:0]    Q,
    output logic                 busy,
    output logic                 err
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       gid_q, gid_d;
    logic                op_q, op_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NLATCH-1:0]   s_q, s_d;
    logic [NLATCH-1:0]   r_q, r_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                err_q, err_d;

    logic                found;
    logic [PW-1:0]       gsel;
    logic [PW-1:0]       cand;
    logic                sel_op;
    logic [IW-1:0]       sel_idx;
    logic                idx_ok;

    // Out-of-range indices decode to all-zero, so no latch is touched.
    function automatic logic [NLATCH-1:0] dec_latch(input logic [IW-1:0] v);
        logic [NLATCH-1:0] d;
        d = '0;
        for (int unsigned j = 0; j < NLATCH; j++) begin
            if (IW'(j) == v) d[j] = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [NREQ-1:0] dec_req(input logic [PW-1:0] v);
        logic [NREQ-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (PW'(k) == v) d[k] = 1'b1;
        end
        return d;
    endfunction

    always_comb begin : arbiter
        found   = 1'b0;
        gsel    = '0;
        cand    = '0;
        sel_op  = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr_q) + int'(i)) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (PW'(k) == gsel) begin
                sel_op  = op[k];
                sel_idx = idx[k*IW +: IW];
            end
        end
    end

    assign idx_ok = |dec_latch(idx_q);

`ifdef SR_CTRL_QCHECK_EN
    logic q_sel;
    assign q_sel = |(Q & dec_latch(idx_q));
`else
    logic unused_q;
    assign unused_q = ^Q;
`endif

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        op_d    = op_q;
        idx_d   = idx_q;
        s_d     = '0;
        r_d     = '0;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                    gid_d   = gsel;
                    op_d    = sel_op;
                    idx_d   = sel_idx;
                    ptr_d   = (gsel == PW'(NREQ - 1)) ? '0 : gsel + 1'b1;
                    gnt_d   = dec_req(gsel);
                    if (sel_op) s_d = dec_latch(sel_idx);
                    else        r_d = dec_latch(sel_idx);
                end
            end
            PULSE: begin
                if (cnt_q == CW'(PULSE_CYC - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    done_d  = dec_req(gid_q);
                    if (!idx_ok) err_d = 1'b1;
`ifdef SR_CTRL_QCHECK_EN
                    // Q sampled at the end of the pulse so err shows on the first GAP cycle.
                    if (idx_ok && (q_sel != op_q)) err_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    s_d   = s_q;
                    r_d   = r_q;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            r_q     <= r_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign S    = s_q;
    assign R    = r_q;
    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl (NLATCH=4, NREQ=2, PULSE_CYC=2, GAP_CYC=1) with a behavioural latch bank.
module tb_sr_latch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  op;
    logic [3:0]  idx;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [3:0]  S;
    logic [3:0]  R;
    logic [3:0]  Q;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SR_CTRL_QCHECK_EN
    localparam logic [3:0] EXP_ERR = 4'h1;
`else
    localparam logic [3:0] EXP_ERR = 4'h0;
`endif

    logic [3:0] q_m = 4'h0;
    logic       hold_q1_low = 1'b0;

    logic [3:0] eg [12];
    logic [3:0] es [12];
    logic [3:0] er [12];
    logic [3:0] ed [12];
    logic [3:0] eb [12];

    always #5 clk = ~clk;

    sr_latch_ctrl #(
        .NLATCH   (4),
        .NREQ     (2),
        .PULSE_CYC(2),
        .GAP_CYC  (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .op   (op),
        .idx  (idx),
        .gnt  (gnt),
        .done (done),
        .S    (S),
        .R    (R),
        .Q    (Q),
        .busy (busy),
        .err  (err)
    );

    always @(posedge clk) q_m <= (q_m | S) & ~R;
    assign Q = q_m & ~{2'b00, hold_q1_low, 1'b0};

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_S"},    S, 4'h0);
        chk({tag, "_R"},    R, 4'h0);
        chk({tag, "_gnt"},  {2'b00, gnt}, 4'h0);
        chk({tag, "_done"}, {2'b00, done}, 4'h0);
        chk({tag, "_busy"}, {3'b000, busy}, 4'h0);
        chk({tag, "_err"},  {3'b000, err}, 4'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        chk_quiet("rst");
        rst_n = 1'b1;
    endtask

    task automatic run_table(input string name, input int drop_at);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("%s_gnt_c%0d", name, i + 1),  {2'b00, gnt}, eg[i]);
            chk($sformatf("%s_S_c%0d", name, i + 1),    S, es[i]);
            chk($sformatf("%s_R_c%0d", name, i + 1),    R, er[i]);
            chk($sformatf("%s_done_c%0d", name, i + 1), {2'b00, done}, ed[i]);
            chk($sformatf("%s_busy_c%0d", name, i + 1), {3'b000, busy}, eb[i]);
            if (i == drop_at) req = 2'b00;
        end
    endtask

    always @(negedge clk) begin
        chk("inv_s_and_r",   S & R, 4'h0);
        chk("inv_sr_onehot", {3'b000, ($countones(S | R) <= 1)}, 4'h1);
        chk("inv_gnt_onehot",  {3'b000, ($countones(gnt) <= 1)}, 4'h1);
        chk("inv_done_onehot", {3'b000, ($countones(done) <= 1)}, 4'h1);
    end

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        op    = 2'b00;
        idx   = 4'h0;

        // Reset then idle
        repeat (3) begin
            tick();
            chk_quiet("reset_hold");
        end
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            chk_quiet("idle");
        end

        // Single set of latch 2 from requester 0
        req = 2'b01;
        op  = 2'b01;
        idx = {2'd0, 2'd2};
        tick();
        chk("set_gnt_c1", {2'b00, gnt}, 4'h1);
        chk("set_S_c1", S, 4'h4);
        chk("set_R_c1", R, 4'h0);
        chk("set_busy_c1", {3'b000, busy}, 4'h1);
        req = 2'b00;
        tick();
        chk("set_gnt_c2", {2'b00, gnt}, 4'h0);
        chk("set_S_c2", S, 4'h4);
        tick();
        chk("set_S_c3", S, 4'h0);
        chk("set_done_c3", {2'b00, done}, 4'h1);
        chk("set_busy_c3", {3'b000, busy}, 4'h1);
        tick();
        chk("set_done_c4", {2'b00, done}, 4'h0);
        chk("set_busy_c4", {3'b000, busy}, 4'h0);
        chk("set_err_c4", {3'b000, err}, 4'h0);

        // Round-robin contention, both requesters held high
        do_reset();
        req = 2'b11;
        op  = 2'b11;
        idx = {2'd1, 2'd0};
        eg = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        es = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
        er = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ed = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        eb = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
        run_table("rr", 8);

        // Opposite operations on latch 3
        do_reset();
        req = 2'b11;
        op  = 2'b01;
        idx = {2'd3, 2'd3};
        eg = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        es = '{4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        er = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ed = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        eb = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        run_table("opp", 4);

        // Reset asserted during the second pulse cycle
        req = 2'b01;
        op  = 2'b01;
        idx = {2'd0, 2'd1};
        tick();
        chk("midrst_gnt_c1", {2'b00, gnt}, 4'h1);
        chk("midrst_S_c1", S, 4'h2);
        req = 2'b00;
        tick();
        chk("midrst_S_c2", S, 4'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_async_S", S, 4'h0);
        chk("midrst_async_R", R, 4'h0);
        chk("midrst_async_busy", {3'b000, busy}, 4'h0);
        tick();
        chk_quiet("midrst_hold");
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            chk_quiet("midrst_after");
        end
        req = 2'b11;
        op  = 2'b11;
        idx = {2'd1, 2'd0};
        tick();
        chk("midrst_ptr_gnt", {2'b00, gnt}, 4'h1);
        chk("midrst_ptr_S", S, 4'h1);
        req = 2'b00;
        repeat (2) tick();
        chk("midrst_ptr_done", {2'b00, done}, 4'h1);
        tick();
        chk("midrst_ptr_idle", {3'b000, busy}, 4'h0);

        // Q readback held low during a set of latch 1
        hold_q1_low = 1'b1;
        req = 2'b01;
        op  = 2'b01;
        idx = {2'd0, 2'd1};
        tick();
        chk("qchk_gnt_c1", {2'b00, gnt}, 4'h1);
        chk("qchk_err_c1", {3'b000, err}, 4'h0);
        req = 2'b00;
        tick();
        chk("qchk_S_c2", S, 4'h2);
        chk("qchk_err_c2", {3'b000, err}, 4'h0);
        tick();
        chk("qchk_done_c3", {2'b00, done}, 4'h1);
        chk("qchk_err_c3", {3'b000, err}, EXP_ERR);
        tick();
        chk("qchk_err_c4", {3'b000, err}, EXP_ERR);
        hold_q1_low = 1'b0;
        req = 2'b01;
        op  = 2'b01;
        idx = {2'd0, 2'd2};
        repeat (4) tick();
        chk("qchk_err_sticky", {3'b000, err}, EXP_ERR);
        do_reset();
        tick();
        chk("qchk_err_cleared", {3'b000, err}, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
